pit_table: RTL

Pending Interest Table of the NDN router. Records forwarded interests, sends unmatched interests to the FIB for longest-prefix routing, and acts as the responder to the FIB's data-propagation handshake. On that handshake it accepts or rejects each returning data prefix; when it accepts, it receives the content bytes, forwards them downstream and retires the entry.

---
 rtl/pit_pkg.sv | 28 ++
 rtl/pit_match.sv | 36 +++
 rtl/pit_table.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared constants, FSM state encodings and the table entry layout for the
// Pending Interest Table.
package pit_pkg;

  localparam int PREFIX_W   = 64;
  localparam int LEN_W      = 6;
  localparam int DATA_BYTES = 1024;

  typedef enum logic [1:0] {
    I_IDLE    = 2'd0,
    I_CHECK   = 2'd1,
    I_FORWARD = 2'd2
  } int_state_e;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_LOOKUP  = 2'd1,
    D_REPLY   = 2'd2,
    D_RECEIVE = 2'd3
  } data_state_e;

  typedef struct packed {
    logic                valid;
    logic [PREFIX_W-1:0] prefix;
    logic [LEN_W-1:0]    len;
  } pit_entry_t;

endpackage

// File: rtl/pit_match.sv
// Parallel comparator over every table slot: reports a matching valid entry
// and the lowest free slot.
module pit_match
  import pit_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  pit_entry_t [ENTRIES-1:0] entries,
  input  logic [PREFIX_W-1:0]      prefix,
  input  logic [LEN_W-1:0]         len,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx,
  output logic                     has_free,
  output logic [IDX_W-1:0]         free_idx
);

  // Scanning downwards leaves the lowest qualifying index in each result.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].len == len && entries[i].prefix == prefix) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entries[i].valid) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pit_table.sv
// Pending Interest Table: records forwarded interests, sends misses to the FIB,
// and answers the FIB's data handshake by streaming content and retiring entries.
module pit_table
  import pit_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = $clog2(ENTRIES + 1),
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  // Interest handshake: a transfer happens on a rising edge where
  // interest_valid && interest_ready; the payload must be stable while valid.
  input  logic                interest_valid,
  input  logic [PREFIX_W-1:0] interest_prefix,
  input  logic [LEN_W-1:0]    interest_len,
  output logic                interest_ready,
  output logic                interest_dropped,
  output logic [PREFIX_W-1:0] pit_in_prefix,
  output logic [LEN_W-1:0]    pit_in_len,
  output logic                fib_out_bit,
  input  logic [PREFIX_W-1:0] pit_out_prefix,
  input  logic [LEN_W-1:0]    pit_out_len,
  input  logic                prefix_ready,
  input  logic [7:0]          out_data,
  output logic                rejected,
  output logic                start_send_to_pit,
  output logic [7:0]          data_out,
  output logic                data_out_valid,
  output logic                data_done,
  output logic [CNT_W-1:0]    entry_count,
  output int_state_e          interest_state,
  output data_state_e         data_state,
  output logic                table_full,
  output logic [IDX_W-1:0]    next_free_idx,
  output logic [IDX_W-1:0]    agg_idx
);

  localparam int BC_W = $clog2(DATA_BYTES) + 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(DATA_BYTES - 1);

  pit_entry_t [ENTRIES-1:0] entries;
  logic [PREFIX_W-1:0]      int_prefix_q, dat_prefix_q;
  logic [LEN_W-1:0]         int_len_q, dat_len_q;
  logic                     i_hit, i_has_free, d_hit, d_has_free, d_hit_q;
  logic [IDX_W-1:0]         i_hit_idx, i_free_idx, d_hit_idx, d_free_idx, d_idx_q;
  logic [BC_W-1:0]          byte_cnt;
  logic                     ins, clr;

  pit_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_int_match (
    .entries(entries), .prefix(int_prefix_q), .len(int_len_q),
    .hit(i_hit), .hit_idx(i_hit_idx), .has_free(i_has_free), .free_idx(i_free_idx)
  );

  pit_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_dat_match (
    .entries(entries), .prefix(dat_prefix_q), .len(dat_len_q),
    .hit(d_hit), .hit_idx(d_hit_idx), .has_free(d_has_free), .free_idx(d_free_idx)
  );

  assign interest_ready = rst && (interest_state == I_IDLE);
  assign table_full     = !d_has_free;
  assign next_free_idx  = d_free_idx;
  assign agg_idx        = i_hit_idx;

  // The slot being cleared is still valid this cycle, so it is never the insert target.
  assign ins = (interest_state == I_CHECK) && !i_hit && i_has_free;
  assign clr = (data_state == D_RECEIVE) && (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries     <= '0;
      entry_count <= '0;
    end else begin
      if (ins) entries[i_free_idx] <= '{valid: 1'b1, prefix: int_prefix_q, len: int_len_q};
      if (clr) entries[d_idx_q].valid <= 1'b0;
      case ({ins, clr})
        2'b10:   entry_count <= entry_count + CNT_W'(1);
        2'b01:   entry_count <= entry_count - CNT_W'(1);
        default: entry_count <= entry_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      interest_state   <= I_IDLE;
      int_prefix_q     <= '0;
      int_len_q        <= '0;
      pit_in_prefix    <= '0;
      pit_in_len       <= '0;
      fib_out_bit      <= 1'b0;
      interest_dropped <= 1'b0;
    end else begin
      fib_out_bit      <= 1'b0;
      interest_dropped <= 1'b0;
      case (interest_state)
        I_IDLE: begin
          if (interest_valid) begin
            int_prefix_q   <= interest_prefix;
            int_len_q      <= interest_len;
            interest_state <= I_CHECK;
          end
        end
        I_CHECK: begin
          if (i_hit) begin
            interest_state <= I_IDLE;
          end else if (i_has_free) begin
            fib_out_bit    <= 1'b1;
            pit_in_prefix  <= int_prefix_q;
            pit_in_len     <= int_len_q;
            interest_state <= I_FORWARD;
          end else begin
            interest_dropped <= 1'b1;
            interest_state   <= I_IDLE;
          end
        end
        default: interest_state <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_state        <= D_IDLE;
      dat_prefix_q      <= '0;
      dat_len_q         <= '0;
      d_hit_q           <= 1'b0;
      d_idx_q           <= '0;
      byte_cnt          <= '0;
      rejected          <= 1'b0;
      start_send_to_pit <= 1'b0;
      data_out          <= '0;
      data_out_valid    <= 1'b0;
      data_done         <= 1'b0;
    end else begin
      rejected          <= 1'b0;
      start_send_to_pit <= 1'b0;
      data_out_valid    <= 1'b0;
      data_done         <= 1'b0;
      case (data_state)
        D_IDLE: begin
          if (prefix_ready) begin
            dat_prefix_q <= pit_out_prefix;
            dat_len_q    <= pit_out_len;
            data_state   <= D_LOOKUP;
          end
        end
        D_LOOKUP: begin
          d_hit_q           <= d_hit;
          d_idx_q           <= d_hit_idx;
          rejected          <= !d_hit;
          start_send_to_pit <= d_hit;
          data_state        <= D_REPLY;
        end
        D_REPLY: begin
          byte_cnt   <= '0;
          data_state <= d_hit_q ? D_RECEIVE : D_IDLE;
        end
        D_RECEIVE: begin
          data_out       <= out_data;
          data_out_valid <= 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            data_done  <= 1'b1;
            data_state <= D_IDLE;
          end else begin
            byte_cnt <= byte_cnt + BC_W'(1);
          end
        end
        default: data_state <= D_IDLE;
      endcase
    end
  end

endmodule
